mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_BYTES, default 64, shall give the size in bytes of the attached byte-addressed data memory.
REQ-002 Clk  input  1  shall be the single clock; all state shall update on its rising edge.
REQ-003 Reset_n  input  1  shall be the reset: asynchronous, active-low.
REQ-004 Req0 / Req1  input  1  shall be the access request from port 0 (CPU MEM stage) and port 1 (debug/loader).
REQ-005 Wr0 / Wr1  input  1  shall select write when 1 and read when 0, per port.
REQ-006 Addr0 / Addr1  input  32  shall be the byte address per port.
REQ-007 WData0 / WData1  input  32  shall be the write data per port (big-endian: [31:24] at Addr).
REQ-008 Ack0 / Ack1  output  1  shall be the one-cycle completion pulse per port.
REQ-009 Err0 / Err1  output  1  shall be the error flag, valid only with the matching Ack.
REQ-010 RData  output  32  shall be the read data returned with Ack, shared by both ports.
REQ-011 Busy  output  1  shall be high whenever the FSM is not IDLE.
REQ-012 MemRead, MemWre  output  1  shall be the memory strobes.
REQ-013 DataAddress, DataIn  output  32  shall be the memory address and write data.
REQ-014 DataOut  input  32  shall be the memory read data (combinational from the memory).

Function
REQ-015 The FSM shall have states IDLE, ACCESS and RESP, with transitions IDLE->ACCESS when Req0|Req1, ACCESS->RESP always, and RESP->IDLE always.
REQ-016 In IDLE, the arbiter shall latch the winner's Wr, Addr and WData into internal registers.
REQ-017 Single request: that port shall win.
REQ-018 Both ports requesting (round-robin): the port not served last shall win, and the last-served pointer shall update on entry to ACCESS.
REQ-019 In ACCESS, DataAddress and DataIn shall be driven from the latched registers, and exactly one of MemRead/MemWre shall be 1 (per latched Wr) unless the access is in error.
REQ-020 On the rising edge ending ACCESS, RData shall capture DataOut for a valid read; for writes and errored accesses it shall capture 0.
REQ-021 In RESP, only the winner's Ack shall be 1, for exactly one cycle.
REQ-022 Latency: a request sampled in IDLE at edge N shall yield Ack high in cycle N+2, giving a fixed three-cycle occupancy per access.
REQ-023 Error: if Addr[1:0]!=0 or Addr>MEM_BYTES-4, both strobes shall stay 0 in ACCESS, Err shall be 1 with the Ack, and the latency shall be unchanged.
REQ-024 Outside ACCESS, MemRead=MemWre=0 and DataAddress=DataIn=0.
REQ-025 A requester shall hold Req and its payload until its Ack.
REQ-026 A Req dropped before Ack shall not abort the access in flight; the Ack shall still be issued.
REQ-027 A Req still high in the RESP cycle shall not restart an access in that cycle; it shall be re-arbitrated in the following IDLE.
REQ-028 The losing port shall wait with no Ack and shall be served in the next IDLE if still requesting.
REQ-029 A port held high continuously shall receive one Ack per three cycles.

Reset
REQ-030 Reset_n low shall immediately force state IDLE and Ack0=Ack1=Err0=Err1=0, RData=0, Busy=0, MemRead=MemWre=0, DataAddress=DataIn=0.
REQ-031 Reset shall set the last-served pointer to port 1, so that port 0 wins the first tie.
REQ-032 Reset asserted during ACCESS shall drop any pending write strobe immediately, discard the transaction, and issue no Ack after release.

Configuration
REQ-033 With MEM_ARB_FIXED_PRIO_EN defined, port 0 shall always win ties and the last-served pointer shall be removed; without it, round-robin per REQ-018 shall apply.

Verification
REQ-034 Port0 write Addr=8, WData=0x11223344, then read Addr=8 -> Ack0 high at N+2 each time, MemWre pulse one cycle, read RData=0x11223344, Err0=0.
REQ-035 Req0 and Req1 both held as reads of 0 and 4 -> Ack order 0,1,0,1 every three cycles (with macro: 0,0,0,...; Ack1 never).
REQ-036 Port1 read Addr=6 (misaligned) and Addr=64 (range) -> Ack1 with Err1=1, RData=0, MemRead never asserted.
REQ-037 Reset_n pulsed low during ACCESS of a port0 write -> MemWre falls immediately, no Ack0, the following read of that address returns its old value.
REQ-038 Req0 dropped one cycle after acceptance -> Ack0 still pulses at N+2, with no second access.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the byte-addressed data memory.
interface mem_arbiter_if;
  logic        req0, req1;
  logic        wr0, wr1;
  logic [31:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        ack0, ack1;
  logic        err0, err1;
  logic [31:0] rdata;
  logic        busy;
  logic        mem_read, mem_wre;
  logic [31:0] data_address, data_in;
  logic [31:0] data_out;

  modport slave (
    input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, data_out,
    output ack0, ack1, err0, err1, rdata, busy, mem_read, mem_wre, data_address, data_in
  );

  modport master (
    output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, data_out,
    input  ack0, ack1, err0, err1, rdata, busy, mem_read, mem_wre, data_address, data_in
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single data memory; fixed three-cycle access.
// Define MEM_ARB_FIXED_PRIO_EN to make port 0 always win ties (no last-served pointer).
module mem_arbiter #(
  parameter int MEM_BYTES = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state_r, state_nxt_s;
  logic        grant1_s;
  logic        sel_wr_s;
  logic [31:0] sel_addr_s, sel_wdata_s;
  logic        win_r, wr_r, err_r;
  logic        ack0_r, ack1_r, err0_r, err1_r, busy_r;
  logic        mem_read_r, mem_wre_r;
  logic [31:0] data_address_r, data_in_r, rdata_r;
`ifndef MEM_ARB_FIXED_PRIO_EN
  logic        last_r;
`endif

  function automatic logic addr_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a > 32'(MEM_BYTES - 4));
  endfunction

  // Pick the winning port and mux its payload.
  always_comb begin
    grant1_s = 1'b0;
    if (bus.req0 && bus.req1) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      grant1_s = 1'b0;
`else
      grant1_s = ~last_r;
`endif
    end else if (bus.req1) begin
      grant1_s = 1'b1;
    end else begin
      grant1_s = 1'b0;
    end
    sel_wr_s    = grant1_s ? bus.wr1    : bus.wr0;
    sel_addr_s  = grant1_s ? bus.addr1  : bus.addr0;
    sel_wdata_s = grant1_s ? bus.wdata1 : bus.wdata0;
  end

  // Next-state logic: a RESP cycle never starts a new access.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = (bus.req0 || bus.req1) ? ACCESS : IDLE;
      ACCESS:  state_nxt_s = RESP;
      RESP:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_nxt_s;
  end

  // Datapath and registered outputs; strobes are loaded on entry to ACCESS so they are valid for that whole cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_r          <= 1'b0;
      wr_r           <= 1'b0;
      err_r          <= 1'b0;
      ack0_r         <= 1'b0;
      ack1_r         <= 1'b0;
      err0_r         <= 1'b0;
      err1_r         <= 1'b0;
      busy_r         <= 1'b0;
      mem_read_r     <= 1'b0;
      mem_wre_r      <= 1'b0;
      data_address_r <= 32'h0;
      data_in_r      <= 32'h0;
      rdata_r        <= 32'h0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      last_r         <= 1'b1;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (state_nxt_s == ACCESS) begin
            win_r          <= grant1_s;
            wr_r           <= sel_wr_s;
            err_r          <= addr_err(sel_addr_s);
            mem_read_r     <= !sel_wr_s && !addr_err(sel_addr_s);
            mem_wre_r      <= sel_wr_s && !addr_err(sel_addr_s);
            data_address_r <= sel_addr_s;
            data_in_r      <= sel_wdata_s;
            busy_r         <= 1'b1;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_r         <= grant1_s;
`endif
          end
        end
        ACCESS: begin
          mem_read_r     <= 1'b0;
          mem_wre_r      <= 1'b0;
          data_address_r <= 32'h0;
          data_in_r      <= 32'h0;
          rdata_r        <= (!wr_r && !err_r) ? bus.data_out : 32'h0;
          ack0_r         <= !win_r;
          ack1_r         <= win_r;
          err0_r         <= !win_r && err_r;
          err1_r         <= win_r && err_r;
        end
        RESP: begin
          ack0_r <= 1'b0;
          ack1_r <= 1'b0;
          err0_r <= 1'b0;
          err1_r <= 1'b0;
          busy_r <= 1'b0;
        end
        default: begin
          ack0_r     <= 1'b0;
          ack1_r     <= 1'b0;
          err0_r     <= 1'b0;
          err1_r     <= 1'b0;
          busy_r     <= 1'b0;
          mem_read_r <= 1'b0;
          mem_wre_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ack0         = ack0_r;
  assign bus.ack1         = ack1_r;
  assign bus.err0         = err0_r;
  assign bus.err1         = err1_r;
  assign bus.rdata        = rdata_r;
  assign bus.busy         = busy_r;
  assign bus.mem_read     = mem_read_r;
  assign bus.mem_wre      = mem_wre_r;
  assign bus.data_address = data_address_r;
  assign bus.data_in      = data_in_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of single transactions plus tie, reset and drop sequences.
module tb_mem_arbiter;

  localparam int MB = 64;

  logic clk;
  logic rst_n;
  mem_arbiter_if bus ();

  mem_arbiter #(.MEM_BYTES(MB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [0:MB-1];
  int total = 0;
  int bad   = 0;

  // Big-endian memory model: combinational read, write on rising edge.
  always_comb begin
    bus.data_out = 32'h0;
    if (bus.data_address <= 32'(MB - 4))
      bus.data_out = {mem[bus.data_address], mem[bus.data_address + 32'd1],
                      mem[bus.data_address + 32'd2], mem[bus.data_address + 32'd3]};
  end

  always @(posedge clk) begin
    if (bus.mem_wre && bus.data_address <= 32'(MB - 4)) begin
      mem[bus.data_address]         <= bus.data_in[31:24];
      mem[bus.data_address + 32'd1] <= bus.data_in[23:16];
      mem[bus.data_address + 32'd2] <= bus.data_in[15:8];
      mem[bus.data_address + 32'd3] <= bus.data_in[7:0];
    end
  end

  typedef struct {
    logic        port;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_port(input logic p, input logic r, input logic w,
                            input logic [31:0] a, input logic [31:0] d);
    if (!p) begin
      bus.req0 = r; bus.wr0 = w; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = r; bus.wr1 = w; bus.addr1 = a; bus.wdata1 = d;
    end
  endtask

  // One transaction, called at a negedge with the arbiter idle.
  task automatic run_txn(input string nm, input logic p, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err);
    logic [1:0] acks;
    drive_port(p, 1'b1, w, a, d);
    @(negedge clk);
    acks = {bus.ack1, bus.ack0};
    chk({nm, ":access_busy_acks"}, {29'h0, bus.busy, acks}, {29'h0, 1'b1, 2'b00});
    chk({nm, ":strobes"}, {30'h0, bus.mem_read, bus.mem_wre},
        {30'h0, !w && !exp_err, w && !exp_err});
    chk({nm, ":data_address"}, bus.data_address, a);
    chk({nm, ":data_in"}, bus.data_in, d);
    @(negedge clk);
    acks = {bus.ack1, bus.ack0};
    chk({nm, ":resp_acks"}, {30'h0, acks}, p ? 32'd2 : 32'd1);
    chk({nm, ":resp_err"}, {31'h0, p ? bus.err1 : bus.err0}, {31'h0, exp_err});
    chk({nm, ":rdata"}, bus.rdata, exp_rd);
    chk({nm, ":resp_strobes"}, {30'h0, bus.mem_read, bus.mem_wre}, 32'h0);
    drive_port(p, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk({nm, ":idle_busy_acks"}, {29'h0, bus.busy, bus.ack1, bus.ack0}, 32'h0);
  endtask

  initial begin
    int mr_cnt;
    logic exp_p;
    for (int i = 0; i < MB; i++) mem[i] = 8'(i);
    vecs[0]  = '{1'b0, 1'b1, 32'd8,          32'h11223344, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 32'd8,          32'h00000000, 32'h11223344, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 32'd0,          32'h00000000, 32'h00010203, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 32'd6,          32'h00000000, 32'h00000000, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 32'd64,         32'h00000000, 32'h00000000, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 32'd60,         32'h00000000, 32'h3C3D3E3F, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 32'd61,         32'h00000000, 32'h00000000, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 32'd60,         32'hDEADBEEF, 32'h00000000, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 32'd60,         32'h00000000, 32'hDEADBEEF, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 32'd64,         32'hFFFFFFFF, 32'h00000000, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 32'hFFFFFFFC,   32'h00000000, 32'h00000000, 1'b1};

    rst_n = 1'b0;
    drive_port(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive_port(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    #12;
    chk("reset_ctrl", {25'h0, bus.ack0, bus.ack1, bus.err0, bus.err1, bus.busy, bus.mem_read, bus.mem_wre}, 32'h0);
    chk("reset_rdata", bus.rdata, 32'h0);
    chk("reset_addr_in", bus.data_address | bus.data_in, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++)
      run_txn($sformatf("vec%0d", i), vecs[i].port, vecs[i].wr, vecs[i].addr,
              vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err);

    // Both ports held: port 0 reads 0, port 1 reads 4. Last served is port 1.
    drive_port(1'b0, 1'b1, 1'b0, 32'd0, 32'h0);
    drive_port(1'b1, 1'b1, 1'b0, 32'd4, 32'h0);
    for (int j = 1; j <= 11; j++) begin
      @(negedge clk);
      if (j % 3 == 2) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
        exp_p = 1'b0;
`else
        exp_p = ((j / 3) % 2 == 1) ? 1'b1 : 1'b0;
`endif
        chk($sformatf("tie%0d_acks", j), {30'h0, bus.ack1, bus.ack0}, exp_p ? 32'd2 : 32'd1);
        chk($sformatf("tie%0d_rdata", j), bus.rdata, exp_p ? 32'h04050607 : 32'h00010203);
      end else begin
        chk($sformatf("tie%0d_noack", j), {30'h0, bus.ack1, bus.ack0}, 32'h0);
      end
    end
    drive_port(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive_port(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("tie_end_busy", {31'h0, bus.busy}, 32'h0);

    // Reset in the middle of a port 0 write to address 8.
    drive_port(1'b0, 1'b1, 1'b1, 32'd8, 32'hCAFEF00D);
    @(negedge clk);
    chk("rst_mid_wre_before", {31'h0, bus.mem_wre}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_wre_after", {30'h0, bus.mem_wre, bus.busy}, 32'h0);
    drive_port(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk($sformatf("rst_mid_noack%0d", j), {31'h0, bus.ack0}, 32'h0);
    end
    run_txn("rst_mid_readback", 1'b0, 1'b0, 32'd8, 32'h0, 32'h11223344, 1'b0);

    // Req0 dropped one cycle after acceptance.
    mr_cnt = 0;
    drive_port(1'b0, 1'b1, 1'b0, 32'd4, 32'h0);
    @(negedge clk);
    if (bus.mem_read) mr_cnt++;
    drive_port(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("drop_ack0", {31'h0, bus.ack0}, 32'h1);
    chk("drop_rdata", bus.rdata, 32'h04050607);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      if (bus.mem_read) mr_cnt++;
      chk($sformatf("drop_idle%0d", j), {30'h0, bus.busy, bus.ack0}, 32'h0);
    end
    chk("drop_single_access", 32'(mr_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
